rs232_rx: RTL and testbench

Oversampling 8N1 RS-232 receiver that pairs with the team's TinyTapeout UART transmitter. It synchronises the raw RxD pin, validates start bits, majority-votes each bit and shifts the bits in LSB-first. Each completed frame is presented with a one-cycle valid strobe; stop-bit failures are flagged as framing errors. Line-idle status and an end-of-packet pulse are provided for packet-oriented users in the top-level wrapper.

---
 rtl/rs232_pkg.sv | 26 ++
 rtl/rs232_baud_tick.sv | 29 ++
 rtl/rs232_rx.sv | 175 +++++++++++++++++
 tb/tb_rs232_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver and its companion transmitter.
// Holds the receiver state encoding, oversample positions and the divider calculation.
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [3:0] OS_MID_LO = 4'd7;
    localparam logic [3:0] OS_MID    = 4'd8;
    localparam logic [3:0] OS_MID_HI = 4'd9;
    localparam logic [3:0] OS_LAST   = 4'd15;

    // Rounded clk cycles per oversample tick.
    function automatic int calc_div(input longint clk_hz, input longint baud,
                                    input longint oversample);
        longint den;
        den = baud * oversample;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous clear restarts the count so ticks align to an external event.
module rs232_baud_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = !clr && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/rs232_rx.sv
// 16x oversampling 8N1 receiver with majority-voted bits, framing-error detection,
// line-idle status and an end-of-packet pulse.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int IDLE_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_err,
    output logic       idle,
    output logic       eop
);

    localparam int DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MAX);

    if (DIV < 2) begin : g_div_check
        $error("rs232_rx: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
    end
    if (OVERSAMPLE != 16) begin : g_os_check
        $error("rs232_rx: only OVERSAMPLE = 16 is supported");
    end

    logic            sync1_reg, rx_s;
    rx_state_t       state_reg, state_next;
    logic [3:0]      os_reg, os_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [1:0]      samp_reg, samp_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_reg, data_next;
    logic            data_valid_reg, valid_next;
    logic            framing_err_reg, ferr_next;
    logic [IW-1:0]   idle_cnt_reg, idle_cnt_next;
    logic            idle_reg, idle_next;
    logic            eop_reg, eop_next;
    logic            got_byte_reg, got_byte_next;
    logic            tick, div_clr, maj, at_mid_hi, at_last;

    rs232_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            rx_s      <= sync1_reg;
        end
    end

    // Vote of the samples taken at os=7, os=8 and the live os=9 sample.
    assign maj       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
    assign at_mid_hi = tick && (os_reg == OS_MID_HI);
    assign at_last   = tick && (os_reg == OS_LAST);

    always_comb begin
        state_next   = state_reg;
        os_next      = os_reg;
        bit_cnt_next = bit_cnt_reg;
        samp_next    = samp_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        div_clr      = 1'b0;

        if (tick && state_reg != IDLE && state_reg != BREAK) begin
            os_next = os_reg + 4'd1;
            if (os_reg == OS_MID_LO) samp_next[0] = rx_s;
            if (os_reg == OS_MID)    samp_next[1] = rx_s;
        end

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next   = START;
                    os_next      = '0;
                    bit_cnt_next = '0;
                    div_clr      = 1'b1;
                end
            end
            START: begin
                if (at_mid_hi && maj) state_next = IDLE;
                else if (at_last)     state_next = DATA;
            end
            DATA: begin
                if (at_mid_hi) shift_next = {maj, shift_reg[7:1]};
                if (at_last) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets the next start edge arrive half a bit early.
                if (at_mid_hi) begin
                    if (maj) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (state_reg != IDLE || !rx_s) begin
            idle_cnt_next = '0;
        end else if (tick && idle_cnt_reg != IDLE_SAT) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
        end
        idle_next     = (idle_cnt_next == IDLE_SAT);
        eop_next      = idle_next && !idle_reg && got_byte_reg;
        got_byte_next = eop_next ? 1'b0 : (valid_next ? 1'b1 : got_byte_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            os_reg          <= '0;
            bit_cnt_reg     <= '0;
            samp_reg        <= '0;
            shift_reg       <= '0;
            data_reg        <= '0;
            data_valid_reg  <= 1'b0;
            framing_err_reg <= 1'b0;
            idle_cnt_reg    <= IDLE_SAT;
            idle_reg        <= 1'b1;
            eop_reg         <= 1'b0;
            got_byte_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            os_reg          <= os_next;
            bit_cnt_reg     <= bit_cnt_next;
            samp_reg        <= samp_next;
            shift_reg       <= shift_next;
            data_reg        <= data_next;
            data_valid_reg  <= valid_next;
            framing_err_reg <= ferr_next;
            idle_cnt_reg    <= idle_cnt_next;
            idle_reg        <= idle_next;
            eop_reg         <= eop_next;
            got_byte_reg    <= got_byte_next;
        end
    end

    assign data        = data_reg;
    assign data_valid  = data_valid_reg;
    assign framing_err = framing_err_reg;
    assign idle        = idle_reg;
    assign eop         = eop_reg;

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx at DIV=2 (32 clk per bit): frame vectors, corner sequences
// and random frames checked against an expected-event model.
`timescale 1ns/1ps
module tb_rs232_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] data;
    logic       data_valid, framing_err, idle, eop;

    rs232_rx #(
        .CLK_HZ     (3_200_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .IDLE_BITS  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .data        (data),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .idle        (idle),
        .eop         (eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;   // 0 = good byte, 1 = framing error
        logic [7:0] b;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop;
        int         pct;    // sender rate in percent of nominal baud
        int         gap;    // idle clk after the frame
    } vec_t;

    ev_t        ev_q[$];
    ev_t        exp_q[$];
    int         eop_q[$];
    int         checks = 0;
    int         errors = 0;
    int         viol   = 0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid)  ev_q.push_back('{0, data, cyc});
            if (framing_err) ev_q.push_back('{1, data, cyc});
            if (eop)         eop_q.push_back(cyc);
            if (data_valid && framing_err) viol++;
            if (!data_valid && data !== data_prev) viol++;
        end
        data_prev = data;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Bit k of a frame occupies clk cycles c with floor(c*pct/3200) == k.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int pct,
                              input int max_cyc, output int start);
        logic [9:0] bits;
        int idx;
        bits  = {stop, b, 1'b0};
        start = 0;
        for (int c = 0; (c * pct) / 3200 < 10 && c < max_cyc; c++) begin
            @(posedge clk);
            #1;
            idx = (c * pct) / 3200;
            rxd = bits[idx];
            if (c == 0) start = cyc;
        end
    endtask

    task automatic apply(input vec_t v);
        int st;
        send_frame(v.b, v.stop, v.pct, 1000, st);
        exp_q.push_back('{(v.stop ? 0 : 1), (v.stop ? v.b : last_good), st});
        if (v.stop) last_good = v.b;
        if (v.gap > 0) begin
            @(posedge clk);
            #1 rxd = 1'b1;
            repeat (v.gap - 1) @(posedge clk);
        end
        $display("frame 0x%02h stop=%0d rate=%0d%% start_cyc=%0d", v.b, v.stop, v.pct, st);
    endtask

    task automatic drain(input string tag);
        ev_t e;
        ev_t a;
        repeat (400) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_missing: got no event, expected kind %0d data 0x%02h", tag, e.kind, e.b);
            end else begin
                a = ev_q.pop_front();
                check({tag, "_kind"}, a.kind, e.kind);
                check({tag, "_data"}, int'(a.b), int'(e.b));
                check_range({tag, "_latency"}, a.cyc - e.cyc, 310, 312);
            end
        end
        check({tag, "_extra_events"}, ev_q.size(), 0);
        ev_q.delete();
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   st;
        int   vcyc;

        vecs[0] = '{8'hA5, 1'b1, 100, 64};
        vecs[1] = '{8'h00, 1'b1, 103, 0};
        vecs[2] = '{8'hFF, 1'b1, 103, 0};
        vecs[3] = '{8'h55, 1'b1, 103, 64};
        vecs[4] = '{8'h00, 1'b1, 97, 0};
        vecs[5] = '{8'hFF, 1'b1, 97, 0};
        vecs[6] = '{8'h55, 1'b1, 97, 64};

        #2 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_data_valid", int'(data_valid), 0);
        check("reset_framing_err", int'(framing_err), 0);
        check("reset_idle", int'(idle), 1);
        check("reset_eop", int'(eop), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Exact-rate byte, then back-to-back groups at +3% and -3%.
        for (int i = 0; i < 7; i++) apply(vecs[i]);
        drain("vec");

        // 8-clk glitch from idle, then a real frame shortly after.
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (8) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (21) @(posedge clk);
        apply('{8'h5A, 1'b1, 100, 64});
        drain("false_start");

        // Bad stop bit followed by a long break, then recovery.
        apply('{8'h3C, 1'b0, 100, 0});
        repeat (500) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        apply('{8'h81, 1'b1, 100, 64});
        drain("break");

        // Idle / end-of-packet.
        repeat (600) @(posedge clk);
        eop_q.delete();
        check("idle_before_frame", int'(idle), 1);
        fork
            apply('{8'h12, 1'b1, 100, 0});
            begin
                repeat (40) @(negedge clk);
                check("idle_during_frame", int'(idle), 0);
            end
        join
        repeat (2600) @(posedge clk);
        vcyc = (ev_q.size() > 0) ? ev_q[0].cyc : -100000;
        check("eop_count", eop_q.size(), 1);
        if (eop_q.size() > 0) check_range("eop_delay", eop_q[0] - vcyc, 511, 513);
        check("idle_after_frame", int'(idle), 1);
        drain("eop");

        // Reset in the middle of data bit 4.
        send_frame(8'h77, 1'b1, 100, 176, st);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midrst_data", int'(data), 0);
        check("midrst_data_valid", int'(data_valid), 0);
        check("midrst_framing_err", int'(framing_err), 0);
        check("midrst_idle", int'(idle), 1);
        check("midrst_eop", int'(eop), 0);
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        last_good = 8'h00;
        ev_q.delete();
        eop_q.delete();
        repeat (50) @(posedge clk);
        apply('{8'h77, 1'b1, 100, 64});
        drain("post_reset");

        // Random bytes, rates within +-3%, occasional bad stop bits.
        for (int i = 0; i < 12; i++) begin
            v.b    = 8'($urandom);
            v.pct  = 97 + int'($urandom_range(0, 6));
            v.stop = ($urandom_range(0, 5) != 0);
            v.gap  = v.stop ? int'($urandom_range(0, 40)) : int'($urandom_range(16, 60));
            apply(v);
        end
        drain("random");

        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
